// File: rtl/serial_cmp.sv
// Bit-serial unsigned magnitude comparator, MSB first.
// Reports X >= Y and X != Y after N valid bits.
module serial_cmp #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic bit_valid,
  input  logic x_bit,
  input  logic y_bit,
  output logic busy,
  output logic done,
  output logic ge,
  output logic ne
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          decided;
  logic          gt;
  logic          dec_nx;
  logic          gt_nx;

  // Only the first differing bit decides; later bits are ignored.
  always_comb begin
    dec_nx = decided;
    gt_nx  = gt;
    if (!decided && (x_bit != y_bit)) begin
      dec_nx = 1'b1;
      gt_nx  = x_bit;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ge      <= 1'b0;
      ne      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= RUN;
            cnt     <= '0;
            decided <= 1'b0;
            gt      <= 1'b0;
            ge      <= 1'b0;
            ne      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (bit_valid) begin
            decided <= dec_nx;
            gt      <= gt_nx;
            if (cnt == LAST) begin
              state <= DONE;
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              ne    <= dec_nx;
              ge    <= dec_nx ? gt_nx : 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= RUN;
            cnt     <= '0;
            decided <= 1'b0;
            gt      <= 1'b0;
            ge      <= 1'b0;
            ne      <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp.sv
// Directed bench for serial_cmp (N=8).
// Expected results and latencies are hand-computed.
module tb_serial_cmp;

  logic clk;
  logic resetn;
  logic start;
  logic bit_valid;
  logic x_bit;
  logic y_bit;
  logic busy;
  logic done;
  logic ge;
  logic ne;

  int checks;
  int errors;

  serial_cmp #(.N(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .bit_valid (bit_valid),
    .x_bit     (x_bit),
    .y_bit     (y_bit),
    .busy      (busy),
    .done      (done),
    .ge        (ge),
    .ne        (ne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one 8-bit comparison and ends in the DONE cycle.
  task automatic compare(input string tag, input logic [7:0] x,
                         input logic [7:0] y, input int stall_at,
                         input int stall_len, input int start_at,
                         input logic exp_ge, input logic exp_ne,
                         input int exp_lat);
    int lat;
    int done_seen;
    lat = 0;
    done_seen = 0;
    start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    chk({tag, "_busy_run"}, busy, 1);
    chk({tag, "_clr"}, {ge, ne}, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        bit_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          lat++;
          if (done) done_seen++;
        end
      end
      bit_valid = 1'b1;
      x_bit = x[7-i];
      y_bit = y[7-i];
      start = (i == start_at);
      tick();
      lat++;
      start = 1'b0;
      if (i < 7 && done) done_seen++;
    end
    bit_valid = 1'b0;
    chk({tag, "_early_done"}, done_seen, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_dn"}, busy, 0);
    chk({tag, "_ge"}, ge, exp_ge);
    chk({tag, "_ne"}, ne, exp_ne);
  endtask

  task automatic idle_after(input string tag, input logic exp_ge,
                            input logic exp_ne);
    tick();
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold"}, {ge, ne}, {exp_ge, exp_ne});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    x_bit = 1'b0;
    y_bit = 1'b0;
    tick();
    tick();
    chk("rst_outs", {busy, done, ge, ne}, 0);
    resetn = 1'b1;
    tick();

    compare("eq", 8'hA5, 8'hA5, -1, 0, -1, 1'b1, 1'b0, 9);
    idle_after("eq", 1'b1, 1'b0);

    compare("msb", 8'h80, 8'h7F, -1, 0, -1, 1'b1, 1'b1, 9);
    idle_after("msb", 1'b1, 1'b1);

    compare("lsb", 8'h3C, 8'h3D, -1, 0, -1, 1'b0, 1'b1, 9);
    idle_after("lsb", 1'b0, 1'b1);

    compare("stall", 8'h01, 8'h02, 4, 3, -1, 1'b0, 1'b1, 12);
    idle_after("stall", 1'b0, 1'b1);

    compare("busy_st", 8'hFF, 8'h00, -1, 0, 4, 1'b1, 1'b1, 9);

    // Start held in DONE restarts immediately.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("chain_busy", busy, 1);
    chk("chain_done", done, 0);
    chk("chain_clr", {ge, ne}, 0);

    // Five bits of a differing pair, then reset mid-operation.
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      x_bit = 1'b1;
      y_bit = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    chk("mid_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("async_rst", {busy, done, ge, ne}, 0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1;
      x_bit = 1'b1;
      y_bit = 1'b0;
      tick();
      chk("no_start", {busy, done, ge, ne}, 0);
    end
    bit_valid = 1'b0;

    compare("post_rst", 8'h3C, 8'h3D, -1, 0, -1, 1'b0, 1'b1, 9);
    idle_after("post_rst", 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
